// File: rtl/fetch_pkg.sv
// Shared types for the fetch sequencer: FSM states, instruction class codes, IR field positions.
package fetch_pkg;

  localparam int PC_W = 8;
  localparam int IR_W = 16;
  localparam int RES_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    MEMWAIT = 3'd2,
    DECODE  = 3'd3,
    EXEC    = 3'd4,
    HALT    = 3'd5,
    ERROR   = 3'd6
  } state_e;

  localparam logic [1:0] CLS_ALU0   = 2'b00;
  localparam logic [1:0] CLS_BRANCH = 2'b01;
  localparam logic [1:0] CLS_ALU1   = 2'b10;
  localparam logic [1:0] CLS_HALT   = 2'b11;

  localparam int IR_CLS_LSB  = 0;
  localparam int IR_CLS_MSB  = 1;
  localparam int IR_COND_LSB = 2;
  localparam int IR_COND_MSB = 3;
  localparam int IR_IMM_LSB  = 4;
  localparam int IR_IMM_MSB  = 11;

  function automatic logic is_alu_cls(input logic [1:0] cls);
    return (cls == CLS_ALU0) || (cls == CLS_ALU1);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle between the fetch sequencer and its neighbours (imem, branch logic, ALU, host start).
interface fetch_sequencer_if;
  import fetch_pkg::*;

  logic             start;
  logic [PC_W-1:0]  imem_addr;
  logic [IR_W-1:0]  imem_data;
  logic [IR_W-1:0]  ir;
  logic [PC_W-1:0]  branch_pc;
  logic             alu_start;
  logic             alu_done;
  logic [RES_W-1:0] alu_result;
  logic [RES_W-1:0] last_result;
  logic             busy;
  logic             halted;
  logic             error;

  modport master (
    input  start, imem_data, branch_pc, alu_done, alu_result,
    output imem_addr, ir, alu_start, last_result, busy, halted, error
  );

  modport slave (
    output start, imem_data, branch_pc, alu_done, alu_result,
    input  imem_addr, ir, alu_start, last_result, busy, halted, error
  );
endinterface

// File: rtl/fetch_wdog_ctr.sv
// EXEC watchdog: counts EXEC cycles spent waiting on the ALU and flags the cycle that reaches TIMEOUT.
module fetch_wdog_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic timeout_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Fires on the waiting cycle that would make the count equal TIMEOUT.
  assign timeout_o = inc_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-path control FSM: owns PC, IR and last ALU result; sequences imem, ALU and branch target.
// Optional EXEC watchdog enabled by defining FETCH_WDOG_EN.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int EXEC_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  fetch_sequencer_if.master   bus
);

  if (EXEC_TIMEOUT < 1) begin : g_bad_timeout
    $error("EXEC_TIMEOUT must be at least 1");
  end

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [IR_W-1:0]  ir_q, ir_d;
  logic [RES_W-1:0] lr_q, lr_d;
  logic             alu_start_q, alu_start_d;
  logic             wd_timeout;
  logic [1:0]       ir_class, mem_class;

  assign ir_class  = ir_q[IR_CLS_MSB:IR_CLS_LSB];
  assign mem_class = bus.imem_data[IR_CLS_MSB:IR_CLS_LSB];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    lr_d        = lr_q;
    alu_start_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          pc_d    = '0;
          state_d = FETCH;
        end
      end
      FETCH:   state_d = MEMWAIT;
      MEMWAIT: state_d = DECODE;
      DECODE: begin
        // Registering the pulse here makes it coincide with the first EXEC cycle.
        ir_d        = bus.imem_data;
        alu_start_d = is_alu_cls(mem_class);
        state_d     = EXEC;
      end
      EXEC: begin
        if (ir_class == CLS_HALT) begin
          state_d = HALT;
        end else if (ir_class == CLS_BRANCH) begin
          pc_d    = bus.branch_pc;
          state_d = FETCH;
        end else if (bus.alu_done) begin
          lr_d    = bus.alu_result;
          pc_d    = pc_q + PC_W'(1);
          state_d = FETCH;
        end else if (wd_timeout) begin
          state_d = ERROR;
        end
      end
      HALT: begin
        if (bus.start) begin
          pc_d    = '0;
          state_d = FETCH;
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      lr_q        <= '0;
      alu_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      lr_q        <= lr_d;
      alu_start_q <= alu_start_d;
    end
  end

`ifdef FETCH_WDOG_EN
  fetch_wdog_ctr #(.TIMEOUT(EXEC_TIMEOUT)) u_wdog (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (state_q == DECODE),
    .inc_i     ((state_q == EXEC) && is_alu_cls(ir_class) && !bus.alu_done),
    .timeout_o (wd_timeout)
  );
  assign bus.error = (state_q == ERROR);
`else
  assign wd_timeout = 1'b0;
  assign bus.error  = 1'b0;
`endif

  assign bus.imem_addr   = pc_q;
  assign bus.ir          = ir_q;
  assign bus.last_result = lr_q;
  assign bus.alu_start   = alu_start_q;
  assign bus.busy        = (state_q == FETCH) || (state_q == MEMWAIT) ||
                           (state_q == DECODE) || (state_q == EXEC);
  assign bus.halted      = (state_q == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: per-instruction reference model plus directed corner cases.
`timescale 1ns/1ps
module tb_fetch_sequencer;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_sequencer_if bus();

  fetch_sequencer #(.EXEC_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] mem [256];
  always @(posedge clk) bus.imem_data <= mem[bus.imem_addr];

  // ALU responder: done comes alu_lat cycles after the alu_start cycle (0 = same cycle).
  int          alu_lat;
  logic [15:0] alu_res;
  bit          alu_hang;
  bit          pend;
  int          remain;
  always @(negedge clk) begin
    if (bus.alu_start && !alu_hang) begin
      pend   = 1'b1;
      remain = alu_lat;
    end
    if (pend && remain == 0) begin
      bus.alu_done = 1'b1;
      pend         = 1'b0;
    end else begin
      bus.alu_done = 1'b0;
      if (pend) remain--;
    end
    bus.alu_result = bus.alu_done ? alu_res : ~alu_res;
  end

  int total = 0;
  int bad   = 0;
  logic [7:0]  m_pc;
  logic [15:0] m_lr;

  task automatic do_reset();
    reset     = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL reset_beats_start: busy=%b want 0", bus.busy);
    end
    reset     = 1'b0;
    bus.start = 1'b0;
    alu_hang  = 1'b0;
    m_pc = 8'h00;
    m_lr = 16'h0000;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Entered on the FETCH cycle; returns on the FETCH (or HALT) cycle of the next step.
  task automatic exec_one(input bit noise, input int lat, input logic [15:0] res,
                          input logic [7:0] bpc, output bit was_halt);
    logic [7:0]  pc0;
    logic [15:0] ins;
    bit          is_alu, is_br, is_halt;
    int          n, starts;
    pc0     = m_pc;
    ins     = mem[pc0];
    is_halt = (ins[1:0] == 2'b11);
    is_br   = (ins[1:0] == 2'b01);
    is_alu  = !ins[0];
    alu_lat = lat;
    alu_res = res;
    bus.branch_pc = bpc;
    n      = is_alu ? 4 + lat : 4;
    starts = 0;
    if (is_alu) begin
      m_pc = 8'(pc0 + 8'd1);
      m_lr = res;
    end else if (is_br) begin
      m_pc = bpc;
    end
    total++;
    if (bus.imem_addr !== pc0 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL fetch_entry: addr=%h busy=%b want addr=%h busy=1", bus.imem_addr, bus.busy, pc0);
    end
    for (int c = 1; c <= n; c++) begin
      if (noise) bus.start = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.alu_start === 1'b1) starts++;
      if (c < n) begin
        total++;
        if (bus.imem_addr !== pc0 || bus.busy !== 1'b1) begin
          bad++; $display("FAIL in_flight c=%0d: addr=%h busy=%b want addr=%h busy=1", c, bus.imem_addr, bus.busy, pc0);
        end
      end
    end
    bus.start = 1'b0;
    total++;
    if (bus.imem_addr !== m_pc) begin
      bad++; $display("FAIL next_pc: got %h want %h (ins %h)", bus.imem_addr, m_pc, ins);
    end
    total++;
    if (bus.last_result !== m_lr) begin
      bad++; $display("FAIL last_result: got %h want %h", bus.last_result, m_lr);
    end
    total++;
    if (bus.ir !== ins) begin
      bad++; $display("FAIL ir: got %h want %h", bus.ir, ins);
    end
    total++;
    if (starts != (is_alu ? 1 : 0)) begin
      bad++; $display("FAIL alu_start_count: got %0d want %0d", starts, is_alu ? 1 : 0);
    end
    total++;
    if (bus.halted !== is_halt || bus.busy !== !is_halt) begin
      bad++; $display("FAIL status: halted=%b busy=%b want halted=%b", bus.halted, bus.busy, is_halt);
    end
    was_halt = is_halt;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({bus.imem_addr, bus.ir, bus.last_result, bus.alu_start, bus.busy, bus.halted, bus.error} !== '0) begin
      bad++; $display("FAIL reset_state: addr=%h ir=%h lr=%h st=%b busy=%b halt=%b err=%b want all 0",
                      bus.imem_addr, bus.ir, bus.last_result, bus.alu_start, bus.busy, bus.halted, bus.error);
    end
  endtask

  task automatic test_alu_branch_wrap();
    bit h;
    do_reset();
    mem[8'h00] = 16'h1230;
    mem[8'h01] = 16'h0451;
    mem[8'h10] = 16'h0005;
    mem[8'hFF] = 16'h0002;
    pulse_start();
    exec_one(1'b0, 2, 16'h0005, 8'h33, h);
    exec_one(1'b0, 0, 16'h7777, 8'h10, h);
    exec_one(1'b0, 1, 16'h8888, 8'hFF, h);
    exec_one(1'b0, 0, 16'hA5A5, 8'h44, h);
    exec_one(1'b0, 3, 16'h1234, 8'h55, h);
  endtask

  task automatic test_halt();
    bit h;
    do_reset();
    mem[0] = 16'h0100;
    mem[1] = 16'h0202;
    mem[2] = 16'h0003;
    pulse_start();
    exec_one(1'b1, 1, 16'h0011, 8'h00, h);
    exec_one(1'b1, 0, 16'h0022, 8'h00, h);
    exec_one(1'b1, 2, 16'h0033, 8'h00, h);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (bus.halted !== 1'b1 || bus.imem_addr !== 8'h02 || bus.ir !== 16'h0003 || bus.alu_start !== 1'b0) begin
        bad++; $display("FAIL halt_hold: halted=%b addr=%h ir=%h st=%b", bus.halted, bus.imem_addr, bus.ir, bus.alu_start);
      end
    end
    pulse_start();
    total++;
    if (bus.imem_addr !== 8'h00 || bus.busy !== 1'b1 || bus.halted !== 1'b0) begin
      bad++; $display("FAIL halt_restart: addr=%h busy=%b halted=%b want 00/1/0", bus.imem_addr, bus.busy, bus.halted);
    end
    m_pc = 8'h00;
    exec_one(1'b0, 0, 16'h0044, 8'h00, h);
  endtask

  task automatic test_reset_mid_exec();
    do_reset();
    mem[0] = 16'h0F00;
    alu_lat = 3;
    alu_res = 16'hBEEF;
    pulse_start();
    for (int c = 1; c <= 3; c++) @(negedge clk);
    total++;
    if (bus.alu_start !== 1'b1) begin
      bad++; $display("FAIL mid_exec_start: alu_start=%b want 1", bus.alu_start);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({bus.imem_addr, bus.ir, bus.last_result, bus.alu_start, bus.busy, bus.halted, bus.error} !== '0) begin
      bad++; $display("FAIL mid_exec_reset: addr=%h ir=%h lr=%h st=%b busy=%b", bus.imem_addr, bus.ir, bus.last_result, bus.alu_start, bus.busy);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (bus.last_result !== 16'h0000 || bus.alu_start !== 1'b0 || bus.busy !== 1'b0) begin
        bad++; $display("FAIL late_done_ignored: lr=%h st=%b busy=%b", bus.last_result, bus.alu_start, bus.busy);
      end
    end
  endtask

  task automatic test_random();
    bit h;
    do_reset();
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    pulse_start();
    for (int k = 0; k < 80; k++) begin
      exec_one(1'b1, $urandom_range(0, 3), 16'($urandom), 8'($urandom), h);
      if (h) begin
        pulse_start();
        m_pc = 8'h00;
      end
    end
  endtask

`ifdef FETCH_WDOG_EN
  task automatic test_wdog();
    do_reset();
    mem[0] = 16'h0000;
    alu_hang = 1'b1;
    pulse_start();
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 6) begin
        total++;
        if (bus.error !== 1'b0 || bus.busy !== 1'b1) begin
          bad++; $display("FAIL wdog_early: error=%b busy=%b want 0/1", bus.error, bus.busy);
        end
      end
    end
    total++;
    if (bus.error !== 1'b1 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL wdog_trip: error=%b busy=%b want 1/0", bus.error, bus.busy);
    end
    for (int i = 0; i < 5; i++) begin
      bus.start = 1'(i & 1);
      @(negedge clk);
      total++;
      if (bus.error !== 1'b1 || bus.imem_addr !== 8'h00 || bus.ir !== 16'h0000 || bus.last_result !== 16'h0000) begin
        bad++; $display("FAIL wdog_hold: error=%b addr=%h ir=%h lr=%h", bus.error, bus.imem_addr, bus.ir, bus.last_result);
      end
    end
    bus.start = 1'b0;
    do_reset();
    total++;
    if (bus.error !== 1'b0) begin
      bad++; $display("FAIL wdog_reset: error=%b want 0", bus.error);
    end
  endtask
`else
  task automatic test_no_wdog();
    do_reset();
    mem[0] = 16'h0000;
    alu_hang = 1'b1;
    alu_res  = 16'h0C0C;
    pulse_start();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      total++;
      if (bus.error !== 1'b0 || bus.busy !== 1'b1) begin
        bad++; $display("FAIL exec_wait: error=%b busy=%b want 0/1", bus.error, bus.busy);
      end
    end
    @(posedge clk);
    pend   = 1'b1;
    remain = 0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus.imem_addr !== 8'h01 || bus.last_result !== 16'h0C0C) begin
      bad++; $display("FAIL exec_late_done: addr=%h lr=%h want 01/0c0c", bus.imem_addr, bus.last_result);
    end
    alu_hang = 1'b0;
  endtask
`endif

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.branch_pc = 8'h00;
    alu_lat = 0;
    alu_res = 16'h0;
    alu_hang = 1'b0;
    pend = 1'b0;
    remain = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    @(negedge clk);
    test_reset();
    test_alu_branch_wrap();
    test_halt();
    test_reset_mid_exec();
    test_random();
`ifdef FETCH_WDOG_EN
    test_wdog();
`else
    test_no_wdog();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
